apb_master_bridge: RTL and testbench



---
 rtl/apb_master_bridge.sv | 189 ++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: takes single valid/ready requests, decodes the slave from the address,
// runs the SETUP/ACCESS handshake with a PREADY timeout and returns a one-cycle response.
//
// state  | meaning
// IDLE   | req_ready high; accept a request or answer unmapped addresses directly
// SETUP  | PSEL asserted, PENABLE low, lasts one cycle
// ACCESS | PENABLE high, waiting on the selected PREADY or the timeout
module apb_master_bridge #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAIN_ADDR_WIDTH = 32,
    parameter int SLAVE_NUM       = 2,
    parameter int SEL_LSB         = 8,
    parameter int TIMEOUT         = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESET_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [MAIN_ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    input  logic [DATA_WIDTH/8-1:0]         req_strb,
    output logic                            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic [MAIN_ADDR_WIDTH-1:0]      PADDR,
    output logic [SLAVE_NUM-1:0]            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    output logic [DATA_WIDTH/8-1:0]         PSTRB,
    input  logic [SLAVE_NUM-1:0]            PREADY,
    input  logic [SLAVE_NUM*DATA_WIDTH-1:0] PRDATA
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int SEL_BITS = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
    localparam int CNT_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                     r_state, w_state_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic                       r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]      r_rsp_rdata, w_rsp_rdata_nxt;
    logic                       r_rsp_err, w_rsp_err_nxt;
    logic [MAIN_ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
    logic [SLAVE_NUM-1:0]       r_psel, w_psel_nxt;
    logic                       r_penable, w_penable_nxt;
    logic                       r_pwrite, w_pwrite_nxt;
    logic [DATA_WIDTH-1:0]      r_pwdata, w_pwdata_nxt;
    logic [STRB_W-1:0]          r_pstrb, w_pstrb_nxt;

    logic [SEL_BITS-1:0]        w_idx;
    logic                       w_unmapped;
    logic [SLAVE_NUM-1:0]       w_psel_dec;
    logic                       w_pready;
    logic [DATA_WIDTH-1:0]      w_prdata;

    assign w_idx      = req_addr[SEL_LSB +: SEL_BITS];
    assign w_unmapped = (32'(w_idx) >= 32'(SLAVE_NUM));
    // PSEL is one-hot, so masking PREADY with it ignores every unselected slave
    assign w_pready   = |(PREADY & r_psel);

    always_comb begin
        w_psel_dec = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            w_psel_dec[i] = (w_idx == SEL_BITS'(i));
        end
    end

    always_comb begin
        w_prdata = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (r_psel[i]) begin
                w_prdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_paddr_nxt     = r_paddr;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_pstrb_nxt     = r_pstrb;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_unmapped) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end else begin
                        w_state_nxt   = ST_SETUP;
                        w_psel_nxt    = w_psel_dec;
                        w_penable_nxt = 1'b0;
                        w_paddr_nxt   = req_addr;
                        w_pwrite_nxt  = req_write;
                        w_pwdata_nxt  = req_wdata;
                        w_pstrb_nxt   = req_write ? req_strb : '0;
                    end
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = CNT_W'(1);
            end
            ST_ACCESS: begin
                if (w_pready) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : w_prdata;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_pstrb_nxt     = '0;
                    w_state_nxt     = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_pstrb_nxt     = '0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_paddr     <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_paddr     <= w_paddr_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pstrb     <= w_pstrb_nxt;
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with three slaves so that select value 3 is unmapped.
module tb_apb_master_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 3;

    logic             PCLK;
    logic             PRESET_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_wdata;
    logic [DW/8-1:0]  req_strb;
    logic             rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic [AW-1:0]    PADDR;
    logic [NS-1:0]    PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [DW-1:0]    PWDATA;
    logic [DW/8-1:0]  PSTRB;
    logic [NS-1:0]    PREADY;
    logic [NS*DW-1:0] PRDATA;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_bridge #(
        .DATA_WIDTH(DW), .MAIN_ADDR_WIDTH(AW), .SLAVE_NUM(NS), .SEL_LSB(8), .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK), .PRESET_n(PRESET_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        int            slv;
        int            delay;
        logic [31:0]   prdata;
        logic          exp_err;
        logic [31:0]   exp_rdata;
        logic [NS-1:0] exp_psel;
        logic [3:0]    exp_pstrb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        PREADY    = '0;
        PRDATA    = {NS{32'h0BAD_0BAD}};
        if (!v.exp_err) PRDATA[v.slv*DW +: DW] = v.prdata;
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_strb  = v.strb;
        chk("accept_ready", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        if (v.exp_err) begin
            chk("unmap_valid", 64'(rsp_valid), 64'(1));
            chk("unmap_err",   64'(rsp_err),   64'(1));
            chk("unmap_rdata", 64'(rsp_rdata), 64'(0));
            chk("unmap_psel",  64'(PSEL),      64'(0));
            chk("unmap_ready", 64'(req_ready), 64'(1));
            tick();
            chk("unmap_pulse", 64'(rsp_valid), 64'(0));
            chk("unmap_psel2", 64'(PSEL),      64'(0));
            return;
        end
        chk("setup_psel",    64'(PSEL),      64'(v.exp_psel));
        chk("setup_penable", 64'(PENABLE),   64'(0));
        chk("setup_paddr",   64'(PADDR),     64'(v.addr));
        chk("setup_pwrite",  64'(PWRITE),    64'(v.wr));
        chk("setup_pstrb",   64'(PSTRB),     64'(v.exp_pstrb));
        chk("setup_ready",   64'(req_ready), 64'(0));
        if (v.wr) chk("setup_pwdata", 64'(PWDATA), 64'(v.wdata));
        tick();
        chk("access_penable", 64'(PENABLE), 64'(1));
        chk("access_psel",    64'(PSEL),    64'(v.exp_psel));
        for (int k = 0; k <= v.delay; k++) begin
            PREADY = (k == v.delay) ? v.exp_psel : '0;
            tick();
            if (k < v.delay) begin
                chk("wait_no_rsp",  64'(rsp_valid), 64'(0));
                chk("wait_penable", 64'(PENABLE),   64'(1));
                chk("wait_psel",    64'(PSEL),      64'(v.exp_psel));
            end
        end
        PREADY = '0;
        chk("rsp_valid",   64'(rsp_valid), 64'(1));
        chk("rsp_err",     64'(rsp_err),   64'(0));
        chk("rsp_rdata",   64'(rsp_rdata), 64'(v.exp_rdata));
        chk("done_psel",   64'(PSEL),      64'(0));
        chk("done_penable",64'(PENABLE),   64'(0));
        chk("done_pstrb",  64'(PSTRB),     64'(0));
        chk("done_paddr",  64'(PADDR),     64'(v.addr));
        chk("done_ready",  64'(req_ready), 64'(1));
        tick();
        chk("rsp_pulse",   64'(rsp_valid), 64'(0));
        chk("rdata_hold",  64'(rsp_rdata), 64'(v.exp_rdata));
    endtask

    initial begin
        vec_t v;
        int   cnt;
        logic seen;

        //            wr    addr          wdata         strb  slv dly prdata        err   exp_rdata     psel    pstrb
        vecs[0] = '{1'b1, 32'h0000_0004, 32'hA5A5_1234, 4'hF, 0, 1, 32'hFFFF_FFFF, 1'b0, 32'h0,        3'b001, 4'hF};
        vecs[1] = '{1'b0, 32'h0000_0108, 32'h1111_2222, 4'hF, 1, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 3'b010, 4'h0};
        vecs[2] = '{1'b0, 32'h0000_020C, 32'h0,         4'h0, 2, 3, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 3'b100, 4'h0};
        vecs[3] = '{1'b1, 32'h0000_0214, 32'h0000_55AA, 4'h3, 2, 2, 32'h7777_7777, 1'b0, 32'h0,        3'b100, 4'h3};
        vecs[4] = '{1'b1, 32'h0000_0300, 32'h1234_5678, 4'hF, 0, 0, 32'h0,         1'b1, 32'h0,        3'b000, 4'h0};
        vecs[5] = '{1'b0, 32'h0000_01FC, 32'h0,         4'h0, 1, 0, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 3'b010, 4'h0};
        vecs[6] = '{1'b0, 32'h0000_00FC, 32'h0,         4'h0, 0, 4, 32'h2468_ACE0, 1'b0, 32'h2468_ACE0, 3'b001, 4'h0};
        vecs[7] = '{1'b0, 32'h0000_03F0, 32'h0,         4'h0, 0, 0, 32'h0,         1'b1, 32'h0,        3'b000, 4'h0};

        PRESET_n  = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        PREADY    = '0;
        PRDATA    = '0;
        tick();
        tick();
        chk("rst_ready",   64'(req_ready), 64'(1));
        chk("rst_valid",   64'(rsp_valid), 64'(0));
        chk("rst_rdata",   64'(rsp_rdata), 64'(0));
        chk("rst_err",     64'(rsp_err),   64'(0));
        chk("rst_paddr",   64'(PADDR),     64'(0));
        chk("rst_psel",    64'(PSEL),      64'(0));
        chk("rst_penable", 64'(PENABLE),   64'(0));
        chk("rst_pwrite",  64'(PWRITE),    64'(0));
        chk("rst_pwdata",  64'(PWDATA),    64'(0));
        chk("rst_pstrb",   64'(PSTRB),     64'(0));
        PRESET_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Timeout: slave 0 never answers
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010; req_strb = 4'hF;
        PREADY = '0;
        tick();
        req_valid = 1'b0;
        tick();
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (PENABLE) cnt++;
            tick();
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("to_seen",    64'(seen),      64'(1));
        chk("to_cycles",  64'(cnt),       64'(16));
        chk("to_err",     64'(rsp_err),   64'(1));
        chk("to_rdata",   64'(rsp_rdata), 64'(0));
        chk("to_psel",    64'(PSEL),      64'(0));
        chk("to_penable", 64'(PENABLE),   64'(0));
        chk("to_ready",   64'(req_ready), 64'(1));
        tick();
        chk("to_pulse",   64'(rsp_valid), 64'(0));
        chk("to_err_hold",64'(rsp_err),   64'(1));

        // Spurious PREADY from slave 1 while slave 0 is addressed, also during SETUP
        PREADY = 3'b011;
        PRDATA = {32'h0BAD_0BAD, 32'h9999_9999, 32'h1234_5678};
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0020;
        tick();
        req_valid = 1'b0;
        PREADY = 3'b011;
        tick();
        chk("sp_setup_ignored", 64'(rsp_valid), 64'(0));
        chk("sp_access",        64'(PENABLE),   64'(1));
        PREADY = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sp_wait", 64'(rsp_valid), 64'(0));
        end
        PREADY = 3'b011;
        tick();
        PREADY = '0;
        chk("sp_valid", 64'(rsp_valid), 64'(1));
        chk("sp_err",   64'(rsp_err),   64'(0));
        chk("sp_rdata", 64'(rsp_rdata), 64'(32'h1234_5678));
        tick();

        // Reset in the middle of an ACCESS wait
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0118;
        req_wdata = 32'hFEED_FACE; req_strb = 4'hC;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("mr_busy", 64'(PENABLE), 64'(1));
        #2;
        PRESET_n = 1'b0;
        #1;
        chk("mr_psel",    64'(PSEL),      64'(0));
        chk("mr_penable", 64'(PENABLE),   64'(0));
        chk("mr_paddr",   64'(PADDR),     64'(0));
        chk("mr_pwdata",  64'(PWDATA),    64'(0));
        chk("mr_pstrb",   64'(PSTRB),     64'(0));
        chk("mr_pwrite",  64'(PWRITE),    64'(0));
        chk("mr_valid",   64'(rsp_valid), 64'(0));
        chk("mr_ready",   64'(req_ready), 64'(1));
        PREADY = 3'b010;
        tick();
        tick();
        chk("mr_no_rsp",  64'(rsp_valid), 64'(0));
        PREADY = '0;
        PRESET_n = 1'b1;
        tick();
        chk("mr_after_valid", 64'(rsp_valid), 64'(0));
        v = vecs[1];
        run_txn(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
